// File: rtl/gate_tt_sequencer_if.sv
// Control/result bundle between the truth-table sequencer and its gate/host side.
// The master modport belongs to the sequencer, the slave modport to the gate and host.
interface gate_tt_sequencer_if #(
    parameter int unsigned N_IN = 3
);
    logic            start;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;

    modport master (
        input  start, gate_out,
        output gate_in, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, gate_out,
        input  gate_in, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Walks a small combinational gate through every input vector and checks it against EXPECT_MASK.
// Build option: define STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_tt_sequencer #(
    parameter int unsigned        N_IN          = 3,
    parameter int unsigned        SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0] EXPECT_MASK   = 8'h80
) (
    input  logic                clk,
    input  logic                rst,
    gate_tt_sequencer_if.master bus
);

    localparam int unsigned N_VEC    = 2**N_IN;
    localparam int unsigned ERR_W    = N_IN + 1;
    localparam int unsigned TMR_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [N_IN-1:0]  r_idx,      w_idx_nxt;
    logic [N_IN-1:0]  r_gate_in,  w_gate_in_nxt;
    logic [N_IN-1:0]  r_fail_vec, w_fail_vec_nxt;
    logic [TMR_W-1:0] r_timer,    w_timer_nxt;
    logic [ERR_W-1:0] r_err,      w_err_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_pass,     w_pass_nxt;

    logic w_accept;
    logic w_mismatch;
    logic w_last;

    // DONE is only restartable once its results are published (r_done high)
    assign w_accept   = bus.start && ((r_state == S_IDLE) || ((r_state == S_DONE) && r_done));
    assign w_mismatch = (bus.gate_out != EXPECT_MASK[r_idx]);
    assign w_last     = (r_idx == LAST_VEC);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_gate_in  <= '0;
            r_fail_vec <= '0;
            r_timer    <= '0;
            r_err      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_gate_in  <= w_gate_in_nxt;
            r_fail_vec <= w_fail_vec_nxt;
            r_timer    <= w_timer_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                w_state_nxt = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (r_timer == TMR_W'(1)) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
`ifdef STOP_ON_FAIL_EN
                if (w_mismatch || w_last) w_state_nxt = S_DONE;
`else
                if (w_last) w_state_nxt = S_DONE;
`endif
                else w_state_nxt = S_DRIVE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Register next-values; results publish one cycle after DONE is entered
    always_comb begin
        w_idx_nxt      = r_idx;
        w_gate_in_nxt  = r_gate_in;
        w_fail_vec_nxt = r_fail_vec;
        w_timer_nxt    = r_timer;
        w_err_nxt      = r_err;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_idx_nxt      = '0;
                    w_err_nxt      = '0;
                    w_fail_vec_nxt = '0;
                    w_pass_nxt     = 1'b0;
                    w_done_nxt     = 1'b0;
                    w_busy_nxt     = 1'b1;
                end else if ((r_state == S_DONE) && !r_done) begin
                    w_done_nxt = 1'b1;
                    w_pass_nxt = (r_err == '0);
                end
            end
            S_DRIVE: begin
                w_gate_in_nxt = r_idx;
                w_timer_nxt   = TMR_W'(SETTLE_CYCLES);
            end
            S_SETTLE: begin
                w_timer_nxt = r_timer - TMR_W'(1);
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + ERR_W'(1);
                    if (r_err == '0) w_fail_vec_nxt = r_idx;
                end
                if (w_state_nxt == S_DONE) w_busy_nxt = 1'b0;
                else                       w_idx_nxt  = r_idx + N_IN'(1);
            end
            default: ;
        endcase
    end

    assign bus.gate_in   = r_gate_in;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_vec  = r_fail_vec;

endmodule
